mio_bus_ctrl: RTL and testbench
===============================

// Module: mio_bus_ctrl
// PURPOSE
//  Memory/IO bus controller directly downstream of the multicycle CPU core. Takes the core's single
//  word access (addr, wdata, we, req) and decodes it to on-chip RAM, GPIO out, switch input or a
//  free-running counter. Inserts RAM wait states and returns read data with a one-cycle MIO_ready.
// PARAMETERS
//  RAM_AW    10     RAM word-address width; RAM occupies byte range 0 .. (4<<RAM_AW)-1
//  RAM_LAT   1      cycles from ram_en to valid ram_rdata (>=1)
//  SW_W      16     switch input width
//  GPIO_RST  32'h0  gpio_out reset value
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       synchronous, active-high
//  cpu_req    in   1       access request (core CPU_MIO)
//  cpu_we     in   1       1=write, 0=read (core mem_w)
//  cpu_addr   in   32      byte address (core Addr_out); addr[1:0] ignored
//  cpu_wdata  in   32      write data (core Data_out)
//  cpu_rdata  out  32      read data (core Data_in); registered, holds last value
//  mio_ready  out  1       one-cycle completion pulse (core MIO_ready)
//  ram_en     out  1       RAM strobe
//  ram_we     out  1       RAM write enable
//  ram_addr   out  RAM_AW  RAM word address = addr[RAM_AW+1:2]
//  ram_wdata  out  32      RAM write data
//  ram_rdata  in   32      RAM read data, valid RAM_LAT cycles after ram_en
//  sw_in      in   SW_W    asynchronous switches
//  gpio_out   out  32      GPIO/LED register
//  bus_err    out  1       one-cycle pulse with mio_ready on an unmapped access
//  bus_state  out  2       FSM state for debug: 0 IDLE, 1 ACCESS, 2 WAIT, 3 DONE
// BEHAVIOUR
//  Reset: state IDLE. cpu_rdata=0, mio_ready=0, ram_en=ram_we=0, bus_err=0, gpio_out=GPIO_RST,
//   cnt=0, sw sync regs=0. Reset mid-access aborts it: no write commits and no rdata update.
//  Address map:
//   - RAM: addr < 4<<RAM_AW.
//   - GPIO: 0xE000_0000 (R/W).
//   - SW: 0xF000_0000 (R; write ignored, no error).
//   - CNT: 0xF000_0004 (R/W).
//   - Everything else is unmapped.
//  FSM:
//   - IDLE: cpu_req=1 latches addr/wdata/we and decodes the region -> ACCESS.
//   - ACCESS (1 cycle):
//     - RAM: ram_en=1, ram_we=latched we; ram_addr/ram_wdata driven from the latch.
//     - RAM read -> WAIT. All other cases -> DONE.
//     - GPIO/CNT writes commit at the end of ACCESS.
//     - Peripheral read data is captured into cpu_rdata at the end of ACCESS.
//   - WAIT: exactly RAM_LAT cycles. ram_rdata is captured into cpu_rdata on the edge ending the
//     last WAIT cycle. -> DONE.
//   - DONE (1 cycle): mio_ready=1; bus_err=1 if unmapped. -> IDLE.
//   - cpu_req is ignored outside IDLE. Req still high in the cycle after DONE = new access.
//  Latency (req sampled in cycle 0): mio_ready in cycle 2 for RAM write, peripheral and unmapped;
//   cycle 2+RAM_LAT for RAM read.
//  Reads: unmapped returns 0. CNT/GPIO return the register value during ACCESS. SW returns
//   {0, sw_sync} after a 2-flop synchronizer.
//  cnt: +1 every cycle, wraps 0xFFFF_FFFF->0. A CNT write loads wdata and wins over the increment
//   in that cycle.
//  ram_en/ram_we are asserted only in ACCESS, never in any other state.
// TESTING
//  1. RAM write 0x10 <- 0x12345678, req at cycle 0 -> cycle 1: ram_en=ram_we=1, ram_addr=4;
//     cycle 2: mio_ready=1.
//  2. RAM read 0x10, model returns 0x12345678 -> RAM_LAT=1: mio_ready at cycle 3,
//     cpu_rdata=0x12345678; RAM_LAT=3: cycle 5.
//  3. Write 0xE000_0000 <- 0xA5 -> gpio_out=0xA5 from cycle 2; read back: rdata 0xA5, ready cycle 2.
//  4. Write CNT <- 100 (req cycle 0), read CNT with req cycle 3 -> cpu_rdata=102, ready cycle 5.
//  5. Read 0x8000_0000 -> ram_en never 1; cycle 2: mio_ready=1, bus_err=1, cpu_rdata=0.
//  6. reset=1 during WAIT of a RAM read -> next cycle IDLE, mio_ready=0, cpu_rdata=0,
//     gpio_out=GPIO_RST; SW read after release returns sw_in.

Source files
------------

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller between the multicycle core and RAM / GPIO / switches / counter.
// One access at a time: IDLE -> ACCESS -> [WAIT x RAM_LAT] -> DONE, with a one-cycle ready pulse.
module mio_bus_ctrl #(
  parameter int          RAM_AW   = 10,
  parameter int          RAM_LAT  = 1,
  parameter int          SW_W     = 16,
  parameter logic [31:0] GPIO_RST = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              mio_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [SW_W-1:0]   sw_in,
  output logic [31:0]       gpio_out,
  output logic              bus_err,
  output logic [1:0]        bus_state
);

  localparam int          LW        = $clog2(RAM_LAT + 1);
  localparam logic [30:0] RAM_WORDS = 31'(1) << RAM_AW;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_e;
  typedef enum logic [2:0] {RG_RAM, RG_GPIO, RG_SW, RG_CNT, RG_NONE} rgn_e;

  typedef struct packed {
    logic              we;
    logic [31:0]       wdata;
    logic [RAM_AW-1:0] waddr;
    rgn_e              rgn;
  } req_t;

  state_e            r_state;
  req_t              r_req;
  logic [LW-1:0]     r_wcnt;
  logic [SW_W-1:0]   r_sw1, r_sw2;
  logic [31:0]       r_cnt, r_gpio, r_rdata;
  logic              r_ready, r_err, r_ram_en, r_ram_we;
  rgn_e              w_rgn;
  logic [31:0]       w_prd;
  logic              w_unused;

  // Byte lane bits play no part in decode: every region is word-granular.
  assign w_unused = &{1'b0, cpu_addr[1:0]};

  always_comb begin
    w_rgn = RG_NONE;
    if ({1'b0, cpu_addr[31:2]} < RAM_WORDS)    w_rgn = RG_RAM;
    else if (cpu_addr[31:2] == 30'h3800_0000)  w_rgn = RG_GPIO;
    else if (cpu_addr[31:2] == 30'h3C00_0000)  w_rgn = RG_SW;
    else if (cpu_addr[31:2] == 30'h3C00_0001)  w_rgn = RG_CNT;
  end

  // Peripheral read data as seen during ACCESS; unmapped reads return zero.
  always_comb begin
    w_prd = 32'h0;
    case (r_req.rgn)
      RG_GPIO: w_prd = r_gpio;
      RG_SW:   w_prd = 32'(r_sw2);
      RG_CNT:  w_prd = r_cnt;
      default: w_prd = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_req    <= '{we: 1'b0, wdata: 32'h0, waddr: '0, rgn: RG_NONE};
      r_wcnt   <= '0;
      r_sw1    <= '0;
      r_sw2    <= '0;
      r_cnt    <= 32'h0;
      r_gpio   <= GPIO_RST;
      r_rdata  <= 32'h0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
    end else begin
      r_sw1    <= sw_in;
      r_sw2    <= r_sw1;
      r_cnt    <= r_cnt + 32'd1;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
      case (r_state)
        S_IDLE: if (cpu_req) begin
          r_req    <= '{we: cpu_we, wdata: cpu_wdata, waddr: cpu_addr[RAM_AW+1:2], rgn: w_rgn};
          r_ram_en <= (w_rgn == RG_RAM);
          r_ram_we <= (w_rgn == RG_RAM) && cpu_we;
          r_state  <= S_ACCESS;
        end
        S_ACCESS: begin
          if (r_req.rgn == RG_RAM && !r_req.we) begin
            r_wcnt  <= LW'(RAM_LAT - 1);
            r_state <= S_WAIT;
          end else begin
            r_ready <= 1'b1;
            r_err   <= (r_req.rgn == RG_NONE);
            r_state <= S_DONE;
            if (!r_req.we) r_rdata <= w_prd;
            if (r_req.we && r_req.rgn == RG_GPIO) r_gpio <= r_req.wdata;
            // The load overrides this cycle's increment.
            if (r_req.we && r_req.rgn == RG_CNT)  r_cnt  <= r_req.wdata;
          end
        end
        S_WAIT: begin
          if (r_wcnt == '0) begin
            r_rdata <= ram_rdata;
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_wcnt <= r_wcnt - LW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_rdata = r_rdata;
  assign mio_ready = r_ready;
  assign bus_err   = r_err;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_req.waddr;
  assign ram_wdata = r_req.wdata;
  assign gpio_out  = r_gpio;
  assign bus_state = r_state;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Randomized bench for mio_bus_ctrl: a word-addressed memory map model with a cycle-based
// counter model predicts read data, latency, bus errors and GPIO state for every access.
module tb_mio_bus_ctrl;

  localparam int          AW    = 10;
  localparam int          LAT   = 3;
  localparam int          SWW   = 16;
  localparam int          WORDS = 1 << AW;
  localparam logic [31:0] GRST  = 32'hC0DE_0001;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0]       cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic [31:0]       cpu_rdata, ram_wdata, ram_rdata, gpio_out;
  logic              mio_ready, ram_en, ram_we, bus_err;
  logic [AW-1:0]     ram_addr;
  logic [SWW-1:0]    sw_in = 16'h1357;
  logic [1:0]        bus_state;

  mio_bus_ctrl #(.RAM_AW(AW), .RAM_LAT(LAT), .SW_W(SWW), .GPIO_RST(GRST)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .mio_ready(mio_ready), .ram_en(ram_en),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .sw_in(sw_in), .gpio_out(gpio_out), .bus_err(bus_err), .bus_state(bus_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ram_init(input int w);
    return (32'(w) * 32'h9E37_79B9) ^ 32'h5A5A_A5A5;
  endfunction

  // Synchronous RAM environment; reads appear LAT cycles after the strobe, junk otherwise.
  logic [31:0] ram_mem [WORDS];
  logic [31:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) ram_mem[i] <= ram_init(i);
    end else if (ram_en && ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
    end
    rd_pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr] : $urandom;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[LAT-1];

  // Reference model state
  typedef enum {T_RAM, T_GPIO, T_SW, T_CNT, T_NONE} tr_e;
  logic [31:0] ref_mem [int];
  logic [31:0] ref_gpio, ref_rdata, cnt_base;
  int          cnt_cyc;
  int          n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic tr_e region(input logic [31:0] a);
    if (a < (32'd4 << AW))                          return T_RAM;
    if (a >= 32'hE000_0000 && a <= 32'hE000_0003)   return T_GPIO;
    if (a >= 32'hF000_0000 && a <= 32'hF000_0003)   return T_SW;
    if (a >= 32'hF000_0004 && a <= 32'hF000_0007)   return T_CNT;
    return T_NONE;
  endfunction

  function automatic logic [31:0] mem_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : ram_init(w);
  endfunction

  task automatic apply_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    cpu_req = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    ref_mem.delete();
    ref_gpio  = GRST;
    ref_rdata = 32'h0;
    cnt_base  = 32'h0;
    cnt_cyc   = cyc;
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    tr_e         r;
    int          c0, k, n_en, w, exp_lat;
    logic [31:0] exp_rd;
    logic        seen;
    r = region(addr);
    w = int'(addr[AW+1:2]);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    c0 = cyc;
    case (r)
      T_RAM:   exp_rd = mem_rd(w);
      T_GPIO:  exp_rd = ref_gpio;
      T_SW:    exp_rd = 32'(sw_in);
      T_CNT:   exp_rd = cnt_base + 32'(c0 + 1 - cnt_cyc);
      default: exp_rd = 32'h0;
    endcase
    exp_lat = (r == T_RAM && !we) ? 2 + LAT : 2;
    seen = 1'b0; n_en = 0; k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        cpu_req = 1'b0;
        chk("state_access", 32'(bus_state), 32'd1);
        chk("ram_en_c1", 32'(ram_en), 32'(r == T_RAM));
        chk("ram_we_c1", 32'(ram_we), 32'(r == T_RAM && we));
        if (r == T_RAM) chk("ram_addr", 32'(ram_addr), 32'(addr >> 2));
        if (r == T_RAM && we) chk("ram_wdata", ram_wdata, wd);
      end
      if (ram_en) n_en++;
      if (mio_ready) seen = 1'b1;
    end
    chk("ready_seen", 32'(seen), 32'd1);
    chk("latency", 32'(k), 32'(exp_lat));
    chk("ram_en_cycles", 32'(n_en), 32'(r == T_RAM));
    chk("bus_err", 32'(bus_err), 32'(r == T_NONE));
    chk("state_done", 32'(bus_state), 32'd3);
    if (!we) ref_rdata = exp_rd;
    if (we && r == T_GPIO) ref_gpio = wd;
    if (we && r == T_CNT) begin cnt_base = wd; cnt_cyc = c0 + 2; end
    if (we && r == T_RAM) ref_mem[w] = wd;
    chk("rdata", cpu_rdata, ref_rdata);
    chk("gpio", gpio_out, ref_gpio);
  endtask

  function automatic logic [31:0] pick_addr(input int sel);
    logic [31:0] a;
    if (sel < 40) return 32'($urandom_range(0, (4 << AW) - 1));
    if (sel < 55) return 32'hE000_0000 | 32'($urandom_range(0, 3));
    if (sel < 65) return 32'hF000_0000 | 32'($urandom_range(0, 3));
    if (sel < 80) return 32'hF000_0004 | 32'($urandom_range(0, 3));
    case ($urandom_range(0, 4))
      0: return 32'd4 << AW;
      1: return 32'hE000_0004;
      2: return 32'hF000_0008;
      3: return 32'hDFFF_FFFC;
      default: begin
        a = $urandom;
        while (region(a) != T_NONE) a = $urandom;
        return a;
      end
    endcase
  endfunction

  initial begin
    apply_reset(3);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_ready", 32'(mio_ready), 32'd0);
    chk("rst_ram_en", 32'({ram_en, ram_we}), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_gpio", gpio_out, GRST);
    chk("rst_state", 32'(bus_state), 32'd0);

    // Directed scenarios
    access(1'b1, 32'h10, 32'h1234_5678);
    access(1'b0, 32'h10, 32'h0);
    chk("ram_readback", cpu_rdata, 32'h1234_5678);
    access(1'b1, 32'hE000_0000, 32'hA5);
    access(1'b0, 32'hE000_0000, 32'h0);
    chk("gpio_readback", cpu_rdata, 32'hA5);
    access(1'b1, 32'hF000_0004, 32'd100);
    access(1'b0, 32'hF000_0004, 32'h0);
    chk("cnt_readback", cpu_rdata, 32'd102);
    access(1'b0, 32'h8000_0000, 32'h0);
    chk("unmapped_zero", cpu_rdata, 32'h0);
    access(1'b1, 32'hF000_0000, 32'hFFFF_FFFF);
    access(1'b1, 32'hF000_0004, 32'hFFFF_FFFE);
    access(1'b0, 32'hF000_0004, 32'h0);
    access(1'b1, (32'd4 << AW) - 32'd4, 32'hCAFE_F00D);
    access(1'b0, (32'd4 << AW) - 32'd1, 32'h0);
    access(1'b1, 32'd4 << AW, 32'hDEAD_BEEF);
    access(1'b0, 32'd4 << AW, 32'h0);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        sw_in = SWW'($urandom);
        repeat (3) @(negedge clk);
      end
      access(1'($urandom_range(0, 1)), pick_addr($urandom_range(0, 99)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during WAIT of a RAM read aborts it
    access(1'b1, 32'hE000_0000, 32'h7777_0000);
    access(1'b0, 32'hE000_0000, 32'h0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("in_wait", 32'(bus_state), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_state", 32'(bus_state), 32'd0);
    chk("abort_ready", 32'(mio_ready), 32'd0);
    chk("abort_rdata", cpu_rdata, 32'h0);
    chk("abort_gpio", gpio_out, GRST);
    reset = 1'b0;
    ref_mem.delete(); ref_gpio = GRST; ref_rdata = 32'h0; cnt_base = 32'h0; cnt_cyc = cyc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_ready", 32'(mio_ready), 32'd0);
    end
    sw_in = 16'hBEEF;
    repeat (3) @(negedge clk);
    access(1'b0, 32'hF000_0000, 32'h0);
    chk("sw_after_reset", cpu_rdata, 32'h0000_BEEF);

    // Reset during ACCESS of a GPIO write: write must not commit
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hE000_0000; cpu_wdata = 32'h1111_2222;
    @(negedge clk);
    cpu_req = 1'b0;
    chk("gpio_wr_access", 32'(bus_state), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_mem.delete(); ref_gpio = GRST; ref_rdata = 32'h0; cnt_base = 32'h0; cnt_cyc = cyc;
    @(negedge clk);
    chk("gpio_no_commit", gpio_out, GRST);
    access(1'b0, 32'hF000_0004, 32'h0);
    access(1'b0, 32'h40, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
